// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM port between the fetch stage and the MEM stage; MEM wins ties.
// Latency: request sampled in IDLE, ready pulses WAIT_CYCLES+1 cycles later, then one RESP cycle.
// Backpressure: requesters hold their request until ready; freeze stalls the pipeline meanwhile.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              freeze_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Count value on the final access cycle, when read data is captured.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              owner_mem_q;   // 1: MEM stage owns the port, 0: fetch
    logic              sram_en_q;
    logic              sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;

    // Arbitration FSM: grants in IDLE, drives the SRAM for WAIT_CYCLES, pulses ready in RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_mem_q  <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (mem_read_i || mem_write_i) begin
                        // MEM is the older instruction; a simultaneous read+write is a write.
                        owner_mem_q  <= 1'b1;
                        sram_en_q    <= 1'b1;
                        sram_we_q    <= mem_write_i;
                        sram_addr_q  <= mem_addr_i;
                        sram_wdata_q <= mem_wdata_i;
                        state_q      <= ACCESS;
                    end else if (if_req_i) begin
                        owner_mem_q <= 1'b0;
                        sram_en_q   <= 1'b1;
                        sram_we_q   <= 1'b0;
                        sram_addr_q <= if_addr_i;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!sram_we_q) begin
                            if (owner_mem_q) begin
                                mem_rdata_q <= sram_rdata_i;
                            end else begin
                                if_rdata_q <= sram_rdata_i;
                            end
                        end
                        if (owner_mem_q) begin
                            mem_ready_q <= 1'b1;
                        end else begin
                            if_ready_q <= 1'b1;
                        end
                        sram_en_q <= 1'b0;
                        sram_we_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    // No grant here so the requester can drop or change its request.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_ready_o   = if_ready_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign mem_ready_o  = mem_ready_q;
    assign sram_en_o    = sram_en_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wdata_o = sram_wdata_q;

    // Stall while anything is requested, except in RESP so the pipeline advances with the data.
    assign freeze_o = (mem_read_i | mem_write_i | if_req_i) & (state_q != RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a cycle-level transaction model.
// Driver pushes expected completions; a negedge monitor checks SRAM bus, ready pulses, rdata, freeze.
// Requesters hold requests until ready; every wait is bounded.
module tb_mem_port_arbiter;
    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_read, mem_write;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
    logic        if_ready, mem_ready, sram_en, sram_we, freeze;

    mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata), .freeze_o(freeze)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Initial memory image shared by the SRAM model and the reference model.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hE3A01005;
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // SRAM model driven purely by the DUT's bus.
    logic [31:0] sram_mem [logic [31:0]];
    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : init_word(a);
    endfunction
    always @(posedge clk) if (sram_en === 1'b1 && sram_we === 1'b1) sram_mem[sram_addr] = sram_wdata;
    always @(negedge clk) sram_rdata = sram_rd(sram_addr);

    // Reference model: memory contents and request-level timing.
    typedef struct {
        bit          owner_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy;
    } sb_t;

    sb_t         sbq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_mrd = 32'h0;
    int          free_cyc = 0;
    bit          mon_en = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Drive requests and push expected completions: MEM first, IF on the next free IDLE.
    task automatic issue(input bit do_if, input bit do_rd, input bit do_wr,
                         input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
        sb_t e;
        int  g;
        if_req = do_if; if_addr = ia;
        mem_read = do_rd; mem_write = do_wr; mem_addr = ma; mem_wdata = wd;
        g = (cyc > free_cyc) ? cyc : free_cyc;
        if (do_rd || do_wr) begin
            e.owner_mem = 1; e.we = do_wr; e.addr = ma; e.wdata = wd;
            if (do_wr) begin
                e.rdata = last_mrd;
                ref_mem[ma] = wd;
            end else begin
                e.rdata = ref_rd(ma);
                last_mrd = e.rdata;
            end
            e.rdy = g + W + 1;
            sbq.push_back(e);
            g = g + W + 2;
        end
        if (do_if) begin
            e.owner_mem = 0; e.we = 0; e.addr = ia; e.wdata = 32'h0;
            e.rdata = ref_rd(ia);
            e.rdy = g + W + 1;
            sbq.push_back(e);
            g = g + W + 2;
        end
        free_cyc = g;
    endtask

    // Hold each request until its ready pulse, bounded.
    task automatic wait_done();
        int n;
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (if_ready === 1'b1) if_req = 0;
            if (mem_ready === 1'b1) begin mem_read = 0; mem_write = 0; end
            if (!if_req && !mem_read && !mem_write) break;
        end
        if (n >= 100) begin
            check("completion_timeout", 64'(n), 64'(0));
            if_req = 0; mem_read = 0; mem_write = 0;
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Monitor: compares every cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rst === 1'b1) begin
            bit   have, due, exp_en;
            sb_t  e;
            have = sbq.size() > 0;
            if (have) e = sbq[0];
            due    = have && (cyc == e.rdy);
            exp_en = have && (cyc >= e.rdy - W) && (cyc < e.rdy);
            check("sram_en", 64'(sram_en), 64'(exp_en));
            if (exp_en) begin
                check("sram_we", 64'(sram_we), 64'(e.we));
                check("sram_addr", 64'(sram_addr), 64'(e.addr));
                if (e.we) check("sram_wdata", 64'(sram_wdata), 64'(e.wdata));
            end
            check("if_ready", 64'(if_ready), 64'(due && !e.owner_mem));
            check("mem_ready", 64'(mem_ready), 64'(due && e.owner_mem));
            check("freeze", 64'(freeze), 64'((if_req | mem_read | mem_write) && !due));
            if (due) begin
                if (e.owner_mem) check("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
                else             check("if_rdata", 64'(if_rdata), 64'(e.rdata));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        logic [31:0] a1, a2, wd;
        rst = 0; if_req = 0; mem_read = 0; mem_write = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;

        // Reset for two cycles, then idle with no requests.
        repeat (2) @(posedge clk);
        #1 rst = 1; free_cyc = cyc; mon_en = 1;
        @(negedge clk);
        check("rst_sram_en", 64'(sram_en), 64'(0));
        check("rst_if_ready", 64'(if_ready), 64'(0));
        check("rst_mem_ready", 64'(mem_ready), 64'(0));
        check("rst_freeze", 64'(freeze), 64'(0));
        check("rst_if_rdata", 64'(if_rdata), 64'(0));
        check("rst_mem_rdata", 64'(mem_rdata), 64'(0));
        @(posedge clk); #1;

        // Fetch read at 0x40.
        issue(1, 0, 0, 32'h40, 32'h0, 32'h0);
        wait_done(); gap(1);
        // Simultaneous fetch and load: MEM first.
        issue(1, 1, 0, 32'h44, 32'h100, 32'h0);
        wait_done(); gap(2);
        // Store; mem_rdata must keep the load value.
        issue(0, 0, 1, 32'h0, 32'h200, 32'hDEADBEEF);
        wait_done(); gap(1);
        // Read and write together behave as a write.
        issue(0, 1, 1, 32'h0, 32'h204, 32'hCAFEF00D);
        wait_done(); gap(1);
        // Read back both stored words.
        issue(1, 1, 0, 32'h204, 32'h200, 32'h0);
        wait_done(); gap(1);

        // Reset during the second ACCESS cycle of a load; request stays held.
        issue(0, 1, 0, 32'h0, 32'h300, 32'h0);
        gap(2);
        rst = 0; sbq.delete(); last_mrd = 32'h0;
        gap(1);
        rst = 1; free_cyc = cyc;
        issue(0, 1, 0, 32'h0, 32'h300, 32'h0);
        wait_done(); gap(1);

        // Randomized traffic over a small address pool.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            a1 = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            a2 = 32'h200 + 32'($urandom_range(0, 7)) * 4;
            wd = $urandom;
            case (kind)
                0: issue(1, 0, 0, a1, a2, wd);
                1: issue(0, 1, 0, a1, a2, wd);
                2: issue(0, 0, 1, a1, a2, wd);
                3: issue(0, 1, 1, a1, a2, wd);
                4: issue(1, 1, 0, a1, a2, wd);
                default: issue(1, 0, 1, a1, a2, wd);
            endcase
            wait_done();
            gap(1 + $urandom_range(0, 2));
        end

        gap(3);
        check("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates and sequences the single shared memory port between the instruction-fetch stage and the MEM stage of the ARM pipeline. It grants one requester at a time and drives a fixed-latency SRAM access through a wait-state counter. It returns read data with a one-cycle ready pulse, and raises `freeze` so the pipeline stalls while any access is outstanding. The MEM-stage requests come from the memRead/memWrite decode carried down the pipeline registers.

## Interface

- `WAIT_CYCLES`, default 3: number of cycles `sram_en` is held per access; legal values are 1 to 15.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address; held stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready` is high.
- `if_ready`  out  1  one-cycle completion pulse.
- `mem_read`  in  1  MEM-stage load request.
- `mem_write`  in  1  MEM-stage store request.
- `mem_addr`  in  ADDR_W  load/store address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data; valid while `mem_ready` is high after a read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `sram_en`  out  1  memory access enable.
- `sram_we`  out  1  1 means write.
- `sram_addr`  out  ADDR_W  memory address.
- `sram_wdata`  out  DATA_W  memory write data.
- `sram_rdata`  in  DATA_W  memory read data; valid on the last access cycle.
- `freeze`  out  1  pipeline stall request.

## Operation

- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE:
  - If `mem_read | mem_write`, grant MEM. Latch the owner, address, write data and `we = mem_write`, then go to ACCESS.
  - Otherwise, if `if_req`, grant IF with `we = 0`, then go to ACCESS.
  - Otherwise stay in IDLE.
- MEM always has priority: it is the older instruction. A losing IF request simply waits.
- If `mem_read` and `mem_write` are both high, the access is treated as a write.
- ACCESS:
  - `sram_en = 1`. `sram_we`, `sram_addr` and `sram_wdata` come from the latched values and are stable for the whole access.
  - The counter starts at 0 and increments each cycle.
  - When `cnt == WAIT_CYCLES-1` on a read, capture `sram_rdata` into the owner's rdata register. Then go to RESP.
- RESP:
  - Pulse the owner's ready signal for exactly one cycle. `sram_en = 0`. Then go to IDLE.
  - No grant is made in RESP. This lets the requester drop its request or present the next one before IDLE samples again.
- On a write completion, `mem_rdata` keeps its previous value.
- `freeze = (mem_read | mem_write | if_req) & ~(state == RESP)`.
  - `freeze` is 0 in RESP, so the pipeline advances on the same edge the requester consumes the data.
- Inputs are sampled only in IDLE. Changes to requests during ACCESS or RESP are ignored until the next IDLE cycle.
- Reset (`rst == 0` at an edge):
  - state → IDLE, counter → 0.
  - `sram_en`, `sram_we`, `if_ready` and `mem_ready` → 0.
  - `sram_addr`, `sram_wdata`, `if_rdata` and `mem_rdata` → 0.
  - `freeze` is combinational: `freeze = 0` only when no request is present.
- Reset during ACCESS aborts the access. There is no ready pulse and `sram_en` is low from the next cycle.

## Timing

- A request is sampled in IDLE at cycle t.
- ACCESS occupies cycles t+1 through t+WAIT_CYCLES.
- RESP (the ready pulse) occurs at cycle t+WAIT_CYCLES+1.
- Total latency from request to ready is WAIT_CYCLES+1 cycles. Back-to-back accesses occupy WAIT_CYCLES+2 cycles each (IDLE, ACCESS, RESP).
- `sram_*` outputs are registered, with no combinational path from request inputs to `sram_*`.
- `if_rdata` and `mem_rdata` are registered and hold their value after the ready pulse until the next read by the same owner.
- `if_ready` and `mem_ready` are never high in the same cycle.

## Test plan

- Reset and idle:
  - Stimulus: hold `rst=0` for 2 cycles, then release with no requests.
  - Required: `sram_en=0`, both ready signals 0, `freeze=0`, both rdata outputs 0.
- Fetch read:
  - Stimulus: `WAIT_CYCLES=3`, `if_req=1`, `if_addr=0x40`, memory returns 0xE3A01005.
  - Required: `sram_en` high for exactly 3 cycles with addr 0x40 and we 0. `if_ready` pulses 4 cycles after the request, with `if_rdata=0xE3A01005`. `freeze` is high for 4 cycles and low in the ready cycle.
- Simultaneous requests:
  - Stimulus: `if_req=1` and `mem_read=1` in the same IDLE cycle, `mem_addr=0x100`.
  - Required: MEM is served first (`mem_ready` at +4). IF is granted on the following IDLE cycle (`if_ready` at +9).
- Store:
  - Stimulus: `mem_write=1`, `mem_addr=0x200`, `mem_wdata=0xDEADBEEF`.
  - Required: `sram_we=1` with that address and data for 3 cycles. `mem_ready` pulses once and `mem_rdata` is unchanged.
- Read and write both high:
  - Stimulus: `mem_read=1` and `mem_write=1` together.
  - Required: `sram_we=1` (write takes precedence).
- Reset mid-access:
  - Stimulus: assert `rst=0` in the second ACCESS cycle.
  - Required: `sram_en=0` on the next cycle, no ready pulse, state IDLE. A request held after reset is then served normally with full latency.
